// File: rtl/apb_mtimer_pkg.sv
// Shared definitions for the APB machine timer: register offsets, bus FSM states
// and the byte-lane merge used by every writable register.
package apb_mtimer_pkg;

    // Word index taken from paddr[4:2]
    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4
    } mtimer_reg_e;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [63:0] MTIMER_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [2:0]  MTIMER_LAST_WORD = 3'd4;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_mtimer_counter.sv
// mtime counter with prescaler, mtimecmp/ctrl storage, bus write merge and the
// registered mtime >= mtimecmp interrupt.
module apb_mtimer_counter
    import apb_mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_reg,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        ctrl_en,
    output logic        mtip
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_reg, presc_next;
    logic [63:0]   mtime_reg, mtime_next;
    logic [63:0]   cmp_reg, cmp_next;
    logic          en_reg, en_next;
    logic          mtip_reg;
    logic          tick;

    always_comb begin
        tick       = en_reg && (presc_reg == PRESC_LAST);
        presc_next = presc_reg;
        if (en_reg) presc_next = tick ? '0 : presc_reg + 1'b1;
        mtime_next = tick ? mtime_reg + 64'd1 : mtime_reg;
        cmp_next   = cmp_reg;
        en_next    = en_reg;
        // A bus write to mtime replaces the increment for that cycle entirely
        if (wr_en) begin
            case (wr_reg)
                REG_MTIME_LO:    mtime_next = {mtime_reg[63:32], merge_lanes(mtime_reg[31:0], wr_data, wr_strb)};
                REG_MTIME_HI:    mtime_next = {merge_lanes(mtime_reg[63:32], wr_data, wr_strb), mtime_reg[31:0]};
                REG_MTIMECMP_LO: cmp_next   = {cmp_reg[63:32], merge_lanes(cmp_reg[31:0], wr_data, wr_strb)};
                REG_MTIMECMP_HI: cmp_next   = {merge_lanes(cmp_reg[63:32], wr_data, wr_strb), cmp_reg[31:0]};
                REG_CTRL: begin
                    if (wr_strb[0]) begin
                        en_next = wr_data[0];
                        if (en_reg && !wr_data[0]) presc_next = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            mtime_reg <= '0;
            cmp_reg   <= MTIMER_CMP_RESET;
            en_reg    <= 1'b1;
            mtip_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            mtime_reg <= mtime_next;
            cmp_reg   <= cmp_next;
            en_reg    <= en_next;
            mtip_reg  <= (mtime_next >= cmp_next);
        end
    end

    assign mtime    = mtime_reg;
    assign mtimecmp = cmp_reg;
    assign ctrl_en  = en_reg;
    assign mtip     = mtip_reg;

endmodule

// File: rtl/apb_mtimer.sv
// APB completer for the RISC-V machine timer: bus FSM with wait states, address
// decode with error response, and the register read mux.
module apb_mtimer
    import apb_mtimer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    output logic        pready,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pwstrb,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        mtip
);

    apb_state_e  state_reg;
    logic [3:0]  wait_cnt_reg;
    logic        pready_reg;
    logic        start_access;
    logic        dec_err;
    logic        wr_en;
    logic [31:0] rd_mux;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        ctrl_en;
    logic        unused_addr;

    assign unused_addr  = ^paddr[31:5];
    assign dec_err      = (paddr[1:0] != 2'b00) || (paddr[4:2] > MTIMER_LAST_WORD);
    // An access phase seen without a preceding setup is taken as both at once
    assign start_access = psel && penable && (state_reg != APB_ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= APB_IDLE;
            wait_cnt_reg <= '0;
            pready_reg   <= 1'b0;
        end else begin
            pready_reg <= 1'b0;
            case (state_reg)
                APB_IDLE:   if (psel && !penable) state_reg <= APB_SETUP;
                APB_SETUP:  if (!psel) state_reg <= APB_IDLE;
                APB_ACCESS: begin
                    if (!psel || wait_cnt_reg == 4'd0) begin
                        state_reg <= APB_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        pready_reg   <= (wait_cnt_reg == 4'd1);
                    end
                end
                default:    state_reg <= APB_IDLE;
            endcase
            if (start_access) begin
                state_reg    <= APB_ACCESS;
                wait_cnt_reg <= 4'(WAIT_STATES);
                pready_reg   <= (WAIT_STATES == 0);
            end
        end
    end

    assign wr_en = pready_reg && psel && penable && pwrite && !dec_err;

    apb_mtimer_counter #(
        .PRESCALE (PRESCALE)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_reg   (paddr[4:2]),
        .wr_data  (pwdata),
        .wr_strb  (pwstrb),
        .mtime    (mtime),
        .mtimecmp (mtimecmp),
        .ctrl_en  (ctrl_en),
        .mtip     (mtip)
    );

    always_comb begin
        rd_mux = '0;
        case (paddr[4:2])
            REG_MTIME_LO:    rd_mux = mtime[31:0];
            REG_MTIME_HI:    rd_mux = mtime[63:32];
            REG_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
            REG_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
            REG_CTRL:        rd_mux = {31'd0, ctrl_en};
            default:         rd_mux = '0;
        endcase
    end

    assign pready  = pready_reg;
    assign pslverr = pready_reg && dec_err;
    assign prdata  = (pready_reg && !pwrite && !dec_err) ? rd_mux : 32'd0;

endmodule

// File: tb/tb_apb_mtimer.sv
// Two timer instances (no wait states / prescale 1, and 3 wait states / prescale 4)
// driven by directed and random APB traffic against an elapsed-cycle timer model.
module tb_apb_mtimer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel [2];
    logic        penable [2];
    logic        pwrite [2];
    logic        pready [2];
    logic        pslverr [2];
    logic        mtip [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];
    logic [3:0]  pwstrb [2];

    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;

    // Model: mtime = base + (phase + edges since k0) / prescale while enabled
    logic [63:0] m_base [2];
    logic [63:0] m_cmp [2];
    longint      m_k0 [2];
    longint      m_phase [2];
    bit          m_en [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mtimer #(.WAIT_STATES(0), .PRESCALE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable[0]), .pready(pready[0]),
        .paddr(paddr[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pwstrb(pwstrb[0]),
        .prdata(prdata[0]), .pslverr(pslverr[0]), .mtip(mtip[0])
    );

    apb_mtimer #(.WAIT_STATES(3), .PRESCALE(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable[1]), .pready(pready[1]),
        .paddr(paddr[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pwstrb(pwstrb[1]),
        .prdata(prdata[1]), .pslverr(pslverr[1]), .mtip(mtip[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint ps(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [63:0] mt_at(input int d, input longint k);
        if (!m_en[d]) return m_base[d];
        return m_base[d] + 64'((m_phase[d] + k - m_k0[d]) / ps(d));
    endfunction

    function automatic longint ps_at(input int d, input longint k);
        if (!m_en[d]) return m_phase[d];
        return (m_phase[d] + k - m_k0[d]) % ps(d);
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] st);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic bit addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[4:0] > 5'h10);
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [31:0] a, input longint k);
        logic [63:0] t;
        t = mt_at(d, k);
        if (addr_err(a)) return 32'h0;
        case (a[4:2])
            3'd0:    return t[31:0];
            3'd1:    return t[63:32];
            3'd2:    return m_cmp[d][31:0];
            3'd3:    return m_cmp[d][63:32];
            default: return {31'd0, m_en[d]};
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_base[d]  = 64'd0;
            m_k0[d]    = cyc;
            m_phase[d] = 0;
            m_en[d]    = 1'b1;
            m_cmp[d]   = 64'hFFFF_FFFF_FFFF_FFFF;
        end
    endtask

    // Apply a write that took effect on clock edge e
    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st, input longint e);
        logic [63:0] t;
        longint      np;
        if (addr_err(a)) return;
        case (a[4:2])
            3'd0, 3'd1: begin
                t = mt_at(d, e - 1);
                if (a[2]) t[63:32] = lane_merge(t[63:32], wd, st);
                else      t[31:0]  = lane_merge(t[31:0], wd, st);
                np = m_en[d] ? (ps_at(d, e - 1) + 1) % ps(d) : m_phase[d];
                m_base[d]  = t;
                m_phase[d] = np;
                m_k0[d]    = e;
            end
            3'd2: m_cmp[d][31:0]  = lane_merge(m_cmp[d][31:0], wd, st);
            3'd3: m_cmp[d][63:32] = lane_merge(m_cmp[d][63:32], wd, st);
            default: begin
                if (st[0] && (wd[0] != m_en[d])) begin
                    m_base[d]  = mt_at(d, e);
                    m_phase[d] = 0;
                    m_k0[d]    = e;
                    m_en[d]    = wd[0];
                end
            end
        endcase
    endtask

    // Starts and ends one time unit after a rising edge
    task automatic apb_xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input bit merged, output logic [31:0] rd);
        int     lows;
        bit     done;
        longint e;
        bit     exp_err;
        exp_err = addr_err(a);
        psel[d] = 1'b1; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pwstrb[d] = st;
        penable[d] = merged;
        if (!merged) begin
            @(posedge clk); #1;
            penable[d] = 1'b1;
        end
        lows = 0; done = 1'b0; e = 0; rd = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pready[d]) begin
                e    = cyc + 1;
                done = 1'b1;
                rd   = prdata[d];
                check_eq($sformatf("prdata d%0d w%0d a=%h", d, wr, a), prdata[d],
                         (wr || exp_err) ? 32'h0 : exp_rd(d, a, cyc));
                check_eq($sformatf("pslverr d%0d a=%h", d, a), pslverr[d], exp_err);
                check_eq($sformatf("mtip_xfer d%0d", d), mtip[d], mt_at(d, cyc) >= m_cmp[d]);
                break;
            end
            lows++;
            @(posedge clk); #1;
        end
        check_eq($sformatf("apb_done d%0d", d), done, 1'b1);
        check_eq($sformatf("wait_cycles d%0d", d), lows, ws(d) + 1);
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (done && wr) model_write(d, a, wd, st, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_eq($sformatf("mtip_idle d%0d", d), mtip[d], mt_at(d, cyc) >= m_cmp[d]);
                check_eq($sformatf("pready_idle d%0d", d), pready[d], 1'b0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] wd;
        int          r;
        int          d;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; pwstrb[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_pready d%0d", i), pready[i], 1'b0);
            check_eq($sformatf("rst_pslverr d%0d", i), pslverr[i], 1'b0);
            check_eq($sformatf("rst_prdata d%0d", i), prdata[i], 32'h0);
            check_eq($sformatf("rst_mtip d%0d", i), mtip[i], 1'b0);
        end
        rst_n = 1'b1;
        model_reset();

        // Reset values through the bus
        apb_xfer(0, 0, 32'h0000_000C, 32'h0, 4'h0, 0, rd);
        apb_xfer(1, 0, 32'h0000_0010, 32'h0, 4'h0, 0, rd);
        apb_xfer(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);

        // Write mtime low then read back after a gap
        apb_xfer(1, 1, 32'h0000_0000, 32'h10, 4'hF, 0, rd);
        idle(7);
        apb_xfer(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);

        // Carry from low into high word, then a single-lane write
        apb_xfer(0, 1, 32'h0000_0004, 32'h0, 4'hF, 0, rd);
        apb_xfer(0, 1, 32'h0000_0000, 32'hFFFF_FFFE, 4'hF, 0, rd);
        apb_xfer(0, 0, 32'h0000_0004, 32'h0, 4'h0, 0, rd);
        apb_xfer(0, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);
        apb_xfer(0, 1, 32'h0000_0000, 32'h0000_AB00, 4'b0010, 0, rd);
        apb_xfer(0, 0, 32'h0000_0000, 32'h0, 4'h0, 1, rd);

        // Compare crossing, then raising mtimecmp clears the interrupt
        apb_xfer(0, 1, 32'h0000_0008, 32'h100, 4'hF, 0, rd);
        apb_xfer(0, 1, 32'h0000_0004, 32'h0, 4'hF, 0, rd);
        apb_xfer(0, 1, 32'h0000_0000, 32'hF0, 4'hF, 0, rd);
        apb_xfer(0, 1, 32'h0000_000C, 32'h0, 4'hF, 0, rd);
        idle(30);
        apb_xfer(0, 1, 32'h0000_000C, 32'h1, 4'hF, 0, rd);
        idle(3);

        // 64-bit wrap of mtime
        apb_xfer(0, 1, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 0, rd);
        apb_xfer(0, 1, 32'h0000_0000, 32'hFFFF_FFFC, 4'hF, 0, rd);
        idle(4);
        apb_xfer(0, 0, 32'h0000_0004, 32'h0, 4'h0, 0, rd);
        apb_xfer(0, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);

        // Decode errors, no-op write, and an aborted access
        apb_xfer(0, 0, 32'h0000_0014, 32'h0, 4'h0, 0, rd);
        apb_xfer(0, 0, 32'h0000_0002, 32'h0, 4'h0, 0, rd);
        apb_xfer(0, 1, 32'h0000_0009, 32'h1234_5678, 4'hF, 0, rd);
        apb_xfer(0, 1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 0, rd);
        apb_xfer(0, 0, 32'h0000_0008, 32'h0, 4'h0, 0, rd);
        psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h0; pwdata[1] = 32'hDEAD_BEEF; pwstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("abort_pready", pready[1], 1'b0);
            @(posedge clk); #1;
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        idle(2);
        apb_xfer(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);

        // Freeze and resume via ctrl.en
        apb_xfer(1, 1, 32'h0000_0010, 32'h0, 4'hF, 0, rd);
        idle(9);
        apb_xfer(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);
        apb_xfer(1, 0, 32'h0000_0010, 32'h0, 4'h0, 0, rd);
        apb_xfer(1, 1, 32'h0000_0010, 32'h1, 4'hF, 0, rd);
        idle(6);
        apb_xfer(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);

        // Random traffic on both instances
        for (int n = 0; n < 200; n++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 8));
            a = $urandom;
            if (r < 8) a[4:0] = 5'(r * 4);
            else       a[4:0] = {3'($urandom_range(0, 4)), 2'($urandom_range(1, 3))};
            wd = $urandom;
            if (a[4:0] == 5'h10) wd[0] = ($urandom_range(0, 3) != 0);
            apb_xfer(d, 1'($urandom_range(0, 1)), a, wd, 4'($urandom), 1'($urandom_range(0, 1)), rd);
            idle(int'($urandom_range(0, 2)));
        end

        // Make dut1 interrupt pending, then reset during a completion cycle
        apb_xfer(1, 1, 32'h0000_0010, 32'h1, 4'hF, 0, rd);
        apb_xfer(1, 1, 32'h0000_000C, 32'h0, 4'hF, 0, rd);
        apb_xfer(1, 1, 32'h0000_0008, 32'h0, 4'hF, 0, rd);
        psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h0; pwdata[1] = 32'h5555_5555; pwstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pready[1]) break;
            @(posedge clk); #1;
        end
        check_eq("rst_pre_pready", pready[1], 1'b1);
        check_eq("rst_pre_mtip", mtip[1], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_pready", pready[1], 1'b0);
        check_eq("rst_mid_prdata", prdata[1], 32'h0);
        check_eq("rst_mid_mtip1", mtip[1], 1'b0);
        check_eq("rst_mid_mtip0", mtip[0], 1'b0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        apb_xfer(1, 0, 32'h0000_000C, 32'h0, 4'h0, 0, rd);
        apb_xfer(1, 0, 32'h0000_0010, 32'h0, 4'h0, 0, rd);
        apb_xfer(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);
        apb_xfer(0, 0, 32'h0000_0000, 32'h0, 4'h0, 0, rd);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
